// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: load/store funct3 encodings, LSU state encoding
// and the sub-word extension helpers used by the load path.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        LSU_IDLE = 1'b0,
        LSU_RMW  = 1'b1
    } lsu_state_e;

    function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic is_signed);
        return {{24{is_signed & b[7]}}, b};
    endfunction

    function automatic logic [31:0] ext_half(input logic [15:0] h, input logic is_signed);
        return {{16{is_signed & h[15]}}, h};
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the LSU: load extraction/extension, sub-word
// store merge into the current memory word, and misaligned/illegal detection.
module lsu_align
    import riscv_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] mem_rd,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data,
    output logic        bad_access
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        byte_sel   = mem_rd[{lane, 3'b000} +: 8];
        half_sel   = lane[1] ? mem_rd[31:16] : mem_rd[15:0];
        load_data  = '0;
        merge_data = mem_rd;
        bad_access = 1'b0;

        if (we) begin
            case (funct3)
                F3_B: merge_data[{lane, 3'b000} +: 8] = wdata[7:0];
                F3_H: begin
                    bad_access = lane[0];
                    merge_data[{lane[1], 4'b0000} +: 16] = wdata;
                end
                F3_W:    bad_access = (lane != 2'b00);
                default: bad_access = 1'b1;
            endcase
        end else begin
            case (funct3)
                F3_B:  load_data = ext_byte(byte_sel, 1'b1);
                F3_BU: load_data = ext_byte(byte_sel, 1'b0);
                F3_H: begin
                    bad_access = lane[0];
                    load_data  = ext_half(half_sel, 1'b1);
                end
                F3_HU: begin
                    bad_access = lane[0];
                    load_data  = ext_half(half_sel, 1'b0);
                end
                F3_W: begin
                    bad_access = (lane != 2'b00);
                    load_data  = mem_rd;
                end
                default: bad_access = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: word-wide access to data_mem, same-cycle loads, single-cycle
// SW, and a stall-plus-write read-modify-write sequence for SB/SH.
module lsu
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              stall,
    output logic              err,
    output logic              mem_we,
    output logic [31:0]       mem_a,
    output logic [31:0]       mem_wd,
    input  logic [31:0]       mem_rd
);

    lsu_state_e  state_q, state_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] load_data, merge_data;
    logic        bad_access;
    logic [31:0] word_idx;
    logic        addr_unused;

    // Upper address bits wrap silently within the memory.
    assign word_idx    = {{(32 - IDX_W){1'b0}}, addr[IDX_W+1:2]};
    assign addr_unused = ^addr[ADDR_W-1:IDX_W+2];

    lsu_align u_align (
        .we        (we),
        .funct3    (funct3),
        .lane      (addr[1:0]),
        .mem_rd    (mem_rd),
        .wdata     (wdata[15:0]),
        .load_data (load_data),
        .merge_data(merge_data),
        .bad_access(bad_access)
    );

    always_comb begin
        state_d = state_q;
        merge_d = merge_q;
        rdata   = '0;
        stall   = 1'b0;
        err     = 1'b0;
        mem_we  = 1'b0;
        mem_a   = word_idx;
        mem_wd  = '0;

        case (state_q)
            LSU_IDLE: begin
                if (req) begin
                    if (bad_access) begin
                        err = 1'b1;
                    end else if (!we) begin
                        rdata = load_data;
                    end else if (funct3 == F3_W) begin
                        mem_we = 1'b1;
                        mem_wd = wdata;
                    end else begin
                        stall   = 1'b1;
                        merge_d = merge_data;
                        state_d = LSU_RMW;
                    end
                end
            end
            LSU_RMW: begin
                mem_we  = 1'b1;
                mem_wd  = merge_q;
                state_d = LSU_IDLE;
            end
            default: state_d = LSU_IDLE;
        endcase

        // Holding outputs low in reset keeps a store aborted mid-RMW from writing.
        if (!rst) begin
            rdata  = '0;
            stall  = 1'b0;
            err    = 1'b0;
            mem_we = 1'b0;
            mem_a  = '0;
            mem_wd = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= LSU_IDLE;
            merge_q <= '0;
        end else begin
            // NOTE: non-blocking so both flops update from the same pre-edge values.
            state_q <= state_d;
            merge_q <= merge_d;
        end
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting between the execute stage and `data_mem`. It converts byte, halfword and word loads and stores into word-wide memory accesses. Loads are aligned and sign- or zero-extended in the request cycle. `data_mem` has no byte enables, so sub-word stores use a two-cycle read-modify-write and stall the core for one cycle.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width from the core
- `IDX_W`, 6, word-index width presented to `data_mem` (64 words)

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-low reset
- `req`  in  1  memory instruction valid this cycle
- `we`  in  1  1 = store, 0 = load
- `funct3`  in  3  access type (LB/LH/LW/LBU/LHU, SB/SH/SW)
- `addr`  in  ADDR_W  byte address from the ALU
- `wdata`  in  32  store data (rs2)
- `rdata`  out  32  aligned, extended load result
- `stall`  out  1  core must hold PC and all inputs this cycle
- `err`  out  1  misaligned or illegal access this cycle
- `mem_we`  out  1  to `data_mem` WE
- `mem_a`  out  32  to `data_mem` A: word index `{zeros, addr[IDX_W+1:2]}`
- `mem_wd`  out  32  to `data_mem` WD
- `mem_rd`  in  32  from `data_mem` RD (combinational read)

## Operation
- FSM states:
  - IDLE: reset state.
  - RMW: write-back cycle of a sub-word store.
- Memory is little-endian. Byte lane `addr[1:0]`; halfword lane `addr[1]`.
- Illegal and misaligned accesses:
  - Misaligned: LH/LHU/SH with `addr[0]=1`; LW/SW with `addr[1:0]!=0`.
  - Illegal: funct3 values 011, 110, 111 for loads; anything other than 000/001/010 for stores.
  - Response: `err=1`, `mem_we=0`, `rdata=0`, no stall, FSM stays IDLE.
- Loads (IDLE, `req&!we`):
  - `rdata` is the extracted lane of `mem_rd`, combinational, in the same cycle.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - `stall=0`.
- SW (IDLE): `mem_we=1`, `mem_wd=wdata`, same cycle, no stall.
- SB/SH (IDLE):
  - `stall=1`, `mem_we=0`.
  - Merged word registered into `merge_q`: `mem_rd` with the addressed lane replaced by `wdata[7:0]` or `wdata[15:0]`.
  - Next state RMW.
- RMW:
  - `mem_we=1`, `mem_wd=merge_q`, `mem_a` from the held `addr`, `stall=0`.
  - Next state IDLE unconditionally.
  - `req`/`we`/`funct3` are ignored in RMW; the core holds them from the stalled cycle.
- `req=0` in IDLE: `mem_we=0`, `stall=0`, `err=0`, `rdata=0`.
- Address bits above `IDX_W+1` are dropped (wrap within 64 words). No error is raised for them.

## Timing
- Reset (async, `rst=0`):
  - State IDLE, `merge_q=0`.
  - All outputs 0: `stall`, `err`, `mem_we`, `rdata`, `mem_wd`, `mem_a`.
  - `mem_a`/`mem_wd` may follow inputs combinationally, but `mem_we` must be 0 while `rst=0`.
- Load latency: 0 cycles (combinational through `data_mem`).
- Write latency:
  - SW commits at the first rising edge after the request.
  - SB/SH commit at the second edge: the request cycle stalls, the RMW cycle writes.
- Reset asserted during RMW: state returns to IDLE and no write occurs. A partial store is dropped, never half-written.
- Back-to-back sub-word stores:
  - Each costs 2 cycles.
  - RMW→IDLE then immediately accepts the next SB/SH, stalling again.
- A load following a store reads the new data in the next cycle. `data_mem` write-then-read ordering is guaranteed by the edge.

## Structure
- Shared package `riscv_pkg`:
  - funct3 constants: `F3_B=3'b000`, `F3_H=3'b001`, `F3_W=3'b010`, `F3_BU=3'b100`, `F3_HU=3'b101`.
  - FSM state encoding `LSU_IDLE=1'b0`, `LSU_RMW=1'b1`.
- One combinational sub-module `lsu_align`:
  - Load lane extraction and extension.
  - Store lane merge.
  - Misalignment/illegal detection.
- FSM and `merge_q` stay in `lsu`.

## Test plan
Preload word 5 with `32'h8899AABB`.
- LB `addr=0x15` → `rdata=32'hFFFFFFAA`, `stall=0`. LBU same address → `32'h000000AA`. LH `0x16` → `32'hFFFF8899`.
- SH `addr=0x16`, `wdata=32'h00001234` → `stall=1` for one cycle, `mem_we=1` next cycle. Word 5 then reads `32'h1234AABB`.
- SB `0x14` `wdata=0x77` followed immediately by SB `0x17` `wdata=0x55` → 4 cycles, two stalls. Word 5 reads `32'h5599AA77`.
- LW `addr=0x13` → `err=1`, `rdata=0`, `mem_we=0`. SW `addr=0x12` → `err=1`, memory unchanged.
- SB `0x14` issued, `rst` pulsed low during RMW → `mem_we` never 1, word 5 still `32'h8899AABB`, state IDLE.
- SW `addr=0x08` `wdata=32'hDEADBEEF`, then LW `0x08` next cycle → `rdata=32'hDEADBEEF`, no stalls.
